p_sync_edge_capture: RTL and testbench

// - Destination-domain consumer of p_SSYNC3DO-style 3-flop synchronizer outputs (one per bit).
// - Deglitches each synchronized level and detects enabled rising/falling edges.
// - Records detected edges in sticky W1C status bits, counts event cycles and raises a masked, registered interrupt.
// - Sits between the CDC synchronizer bank and the core CSR/interrupt logic; everything runs on one clock.

---
 rtl/p_sync_edge_capture.sv | 82 ++++++++
 tb/tb_p_sync_edge_capture.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/p_sync_edge_capture.sv
// Deglitches synchronized input levels, detects enabled edges, and keeps sticky status bits.
// It also keeps a saturating event counter and drives a masked, registered interrupt.
module p_sync_edge_capture #(
  parameter int WIDTH    = 4,
  parameter int FILT     = 2,
  parameter int CNT_W    = 8,
  parameter bit IDLE_LVL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sync_in,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] intr_mask,
  input  logic [WIDTH-1:0] status_clr,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] flt_lvl,
  output logic [WIDTH-1:0] evt_pulse,
  output logic [WIDTH-1:0] status,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             intr
);

  localparam logic [3:0]       FILT_LAST = 4'(FILT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [3:0]       stab_cnt [WIDTH];
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] evt_now;

  // A bit is accepted once it has differed from the filtered level for FILT samples.
  always_comb begin
    accept  = '0;
    evt_now = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i]  = (sync_in[i] != flt_lvl[i]) && (stab_cnt[i] == FILT_LAST);
      evt_now[i] = accept[i] && (sync_in[i] ? rise_en[i] : fall_en[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flt_lvl <= {WIDTH{IDLE_LVL}};
      for (int i = 0; i < WIDTH; i++) stab_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_in[i] == flt_lvl[i]) begin
          stab_cnt[i] <= '0;
        end else if (accept[i]) begin
          flt_lvl[i]  <= sync_in[i];
          stab_cnt[i] <= '0;
        end else begin
          stab_cnt[i] <= stab_cnt[i] + 4'd1;
        end
      end
    end
  end

  // A new event takes precedence over a coincident write-1-to-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_pulse <= '0;
      status    <= '0;
      intr      <= 1'b0;
    end else begin
      evt_pulse <= evt_now;
      status    <= (status & ~status_clr) | evt_now;
      intr      <= |(status & intr_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_cnt <= '0;
    end else if (cnt_clr) begin
      evt_cnt <= (|evt_now) ? CNT_W'(1) : '0;
    end else if ((|evt_now) && (evt_cnt != CNT_MAX)) begin
      evt_cnt <= evt_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_p_sync_edge_capture.sv
// Scoreboard bench for p_sync_edge_capture with FILT=2 and a 2-bit counter to reach saturation.
module tb_p_sync_edge_capture;

  localparam int WIDTH = 4;
  localparam int FILT  = 2;
  localparam int CNT_W = 2;
  localparam int VW    = 3 * WIDTH + CNT_W + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] sync_in, rise_en, fall_en, intr_mask, status_clr;
  logic             cnt_clr;
  logic [WIDTH-1:0] flt_lvl, evt_pulse, status;
  logic [CNT_W-1:0] evt_cnt;
  logic             intr;

  int checks   = 0;
  int failures = 0;

  logic [VW-1:0] sb_q[$];
  logic [VW-1:0] exp_v;

  // Independent reference state, advanced once per driven cycle.
  logic [WIDTH-1:0] m_flt, m_pulse, m_status;
  int               m_stab [WIDTH];
  int               m_cnt;
  logic             m_intr;

  p_sync_edge_capture #(.WIDTH(WIDTH), .FILT(FILT), .CNT_W(CNT_W), .IDLE_LVL(1'b1)) dut (
    .clk(clk), .rst(rst), .sync_in(sync_in), .rise_en(rise_en), .fall_en(fall_en),
    .intr_mask(intr_mask), .status_clr(status_clr), .cnt_clr(cnt_clr),
    .flt_lvl(flt_lvl), .evt_pulse(evt_pulse), .status(status), .evt_cnt(evt_cnt), .intr(intr)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] act_vec();
    return {flt_lvl, evt_pulse, status, evt_cnt, intr};
  endfunction

  // Predict the outputs after the coming edge, push them, then advance one clock.
  task automatic cycle();
    logic [WIDTH-1:0] ev;
    logic             new_intr;
    ev = '0;
    if (rst) begin
      m_flt = '1; m_pulse = '0; m_status = '0; m_cnt = 0; m_intr = 1'b0;
      for (int i = 0; i < WIDTH; i++) m_stab[i] = 0;
    end else begin
      new_intr = |(m_status & intr_mask);
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_in[i] == m_flt[i]) begin
          m_stab[i] = 0;
        end else if (m_stab[i] + 1 >= FILT) begin
          m_flt[i]  = sync_in[i];
          m_stab[i] = 0;
          ev[i] = sync_in[i] ? rise_en[i] : fall_en[i];
        end else begin
          m_stab[i] = m_stab[i] + 1;
        end
      end
      if (cnt_clr) m_cnt = (ev != 0) ? 1 : 0;
      else if (ev != 0 && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
      m_pulse  = ev;
      m_status = (m_status & ~status_clr) | ev;
      m_intr   = new_intr;
    end
    sb_q.push_back({m_flt, m_pulse, m_status, CNT_W'(m_cnt), m_intr});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sync_in = '1; rise_en = '1; fall_en = '1; intr_mask = '1;
    status_clr = '0; cnt_clr = 1'b0;
    cycle();
    exp_v = sb_q.pop_front(); checks++;
    if (act_vec() !== exp_v) begin failures++; $display("[TB] FAIL reset_sb got=%h want=%h", act_vec(), exp_v); end
    checks++;
    if ({flt_lvl, evt_pulse, status, evt_cnt, intr} !== {4'hF, 4'h0, 4'h0, 2'd0, 1'b0}) begin
      failures++; $display("[TB] FAIL reset_state flt=%h pulse=%h status=%h cnt=%0d intr=%b", flt_lvl, evt_pulse, status, evt_cnt, intr);
    end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      exp_v = sb_q.pop_front(); checks++;
      if (act_vec() !== exp_v) begin failures++; $display("[TB] FAIL idle_sb cyc=%0d got=%h want=%h", k, act_vec(), exp_v); end
    end
    checks++;
    if (flt_lvl !== 4'hF || evt_pulse !== 4'h0 || status !== 4'h0 || intr !== 1'b0) begin
      failures++; $display("[TB] FAIL idle_state flt=%h pulse=%h status=%h intr=%b", flt_lvl, evt_pulse, status, intr);
    end
  endtask

  task automatic test_fall_event();
    sync_in = 4'hE;
    cycle();
    exp_v = sb_q.pop_front(); checks++;
    if (act_vec() !== exp_v) begin failures++; $display("[TB] FAIL fall_e0_sb got=%h want=%h", act_vec(), exp_v); end
    checks++;
    if (flt_lvl !== 4'hF || evt_pulse !== 4'h0) begin failures++; $display("[TB] FAIL fall_e0 flt=%h pulse=%h want F/0", flt_lvl, evt_pulse); end
    cycle();
    exp_v = sb_q.pop_front(); checks++;
    if (act_vec() !== exp_v) begin failures++; $display("[TB] FAIL fall_e1_sb got=%h want=%h", act_vec(), exp_v); end
    checks++;
    if (flt_lvl !== 4'hE || evt_pulse !== 4'h1 || status !== 4'h1 || evt_cnt !== 2'd1 || intr !== 1'b0) begin
      failures++; $display("[TB] FAIL fall_e1 flt=%h pulse=%h status=%h cnt=%0d intr=%b want E/1/1/1/0", flt_lvl, evt_pulse, status, evt_cnt, intr);
    end
    cycle();
    exp_v = sb_q.pop_front(); checks++;
    if (act_vec() !== exp_v) begin failures++; $display("[TB] FAIL fall_e2_sb got=%h want=%h", act_vec(), exp_v); end
    checks++;
    if (evt_pulse !== 4'h0 || intr !== 1'b1) begin failures++; $display("[TB] FAIL fall_e2 pulse=%h intr=%b want 0/1", evt_pulse, intr); end
  endtask

  task automatic test_glitch();
    sync_in = 4'hC;
    for (int k = 0; k < 4; k++) begin
      cycle();
      sync_in = 4'hE;
      exp_v = sb_q.pop_front(); checks++;
      if (act_vec() !== exp_v) begin failures++; $display("[TB] FAIL glitch_sb cyc=%0d got=%h want=%h", k, act_vec(), exp_v); end
    end
    checks++;
    if (flt_lvl !== 4'hE || evt_pulse !== 4'h0 || evt_cnt !== 2'd1) begin
      failures++; $display("[TB] FAIL glitch flt=%h pulse=%h cnt=%0d want E/0/1", flt_lvl, evt_pulse, evt_cnt);
    end
  endtask

  task automatic test_status_clr();
    sync_in = 4'hF;
    cycle();
    exp_v = sb_q.pop_front(); checks++;
    if (act_vec() !== exp_v) begin failures++; $display("[TB] FAIL clr_e0_sb got=%h want=%h", act_vec(), exp_v); end
    status_clr = 4'h1;
    cycle();
    exp_v = sb_q.pop_front(); checks++;
    if (act_vec() !== exp_v) begin failures++; $display("[TB] FAIL set_wins_sb got=%h want=%h", act_vec(), exp_v); end
    checks++;
    if (status[0] !== 1'b1 || evt_pulse !== 4'h1) begin failures++; $display("[TB] FAIL set_wins status=%h pulse=%h want status[0]=1", status, evt_pulse); end
    cycle();
    status_clr = 4'h0;
    exp_v = sb_q.pop_front(); checks++;
    if (act_vec() !== exp_v) begin failures++; $display("[TB] FAIL clr_only_sb got=%h want=%h", act_vec(), exp_v); end
    checks++;
    if (status !== 4'h0 || intr !== 1'b1) begin failures++; $display("[TB] FAIL clr_only status=%h intr=%b want 0/1", status, intr); end
    cycle();
    exp_v = sb_q.pop_front(); checks++;
    if (act_vec() !== exp_v) begin failures++; $display("[TB] FAIL clr_intr_sb got=%h want=%h", act_vec(), exp_v); end
    checks++;
    if (intr !== 1'b0) begin failures++; $display("[TB] FAIL clr_intr intr=%b want 0", intr); end
  endtask

  task automatic test_multi_bit();
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    exp_v = sb_q.pop_front(); checks++;
    if (act_vec() !== exp_v || evt_cnt !== 2'd0) begin failures++; $display("[TB] FAIL cnt_clr got=%h want=%h", act_vec(), exp_v); end
    fall_en = 4'hB; intr_mask = 4'h0; sync_in = 4'h9;
    for (int k = 0; k < 2; k++) begin
      cycle();
      exp_v = sb_q.pop_front(); checks++;
      if (act_vec() !== exp_v) begin failures++; $display("[TB] FAIL disabled_sb cyc=%0d got=%h want=%h", k, act_vec(), exp_v); end
    end
    checks++;
    if (flt_lvl !== 4'h9 || evt_pulse !== 4'h2 || evt_cnt !== 2'd1) begin
      failures++; $display("[TB] FAIL disabled flt=%h pulse=%h cnt=%0d want 9/2/1", flt_lvl, evt_pulse, evt_cnt);
    end
    fall_en = 4'hF; sync_in = 4'hF;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (k == 1) intr_mask = 4'h2;
      exp_v = sb_q.pop_front(); checks++;
      if (act_vec() !== exp_v) begin failures++; $display("[TB] FAIL multi_sb cyc=%0d got=%h want=%h", k, act_vec(), exp_v); end
    end
    checks++;
    if (evt_cnt !== 2'd2 || status !== 4'h6) begin failures++; $display("[TB] FAIL multi cnt=%0d status=%h want 2/6", evt_cnt, status); end
    cycle();
    intr_mask = 4'hF;
    exp_v = sb_q.pop_front(); checks++;
    if (act_vec() !== exp_v || intr !== 1'b1) begin failures++; $display("[TB] FAIL unmask intr=%b got=%h want=%h", intr, act_vec(), exp_v); end
  endtask

  task automatic test_counter_sat();
    logic [CNT_W-1:0] want_cnt [5];
    logic             lvl3;
    want_cnt[0] = 2'd1; want_cnt[1] = 2'd2; want_cnt[2] = 2'd3; want_cnt[3] = 2'd3; want_cnt[4] = 2'd3;
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    exp_v = sb_q.pop_front();
    lvl3 = flt_lvl[3];
    for (int k = 0; k < 5; k++) begin
      lvl3 = ~lvl3;
      sync_in[3] = lvl3;
      for (int c = 0; c < 3; c++) begin
        cycle();
        exp_v = sb_q.pop_front(); checks++;
        if (act_vec() !== exp_v) begin failures++; $display("[TB] FAIL sat_sb evt=%0d cyc=%0d got=%h want=%h", k, c, act_vec(), exp_v); end
        if (c == 1) begin
          checks++;
          if (evt_cnt !== want_cnt[k]) begin failures++; $display("[TB] FAIL sat_cnt evt=%0d cnt=%0d want=%0d", k, evt_cnt, want_cnt[k]); end
        end
      end
    end
    sync_in[3] = ~lvl3;
    cycle();
    cnt_clr = 1'b1;
    exp_v = sb_q.pop_front();
    cycle();
    cnt_clr = 1'b0;
    exp_v = sb_q.pop_front(); checks++;
    if (act_vec() !== exp_v || evt_cnt !== 2'd1) begin failures++; $display("[TB] FAIL clr_with_evt cnt=%0d got=%h want=%h", evt_cnt, act_vec(), exp_v); end
  endtask

  task automatic test_reset_mid_filter();
    sync_in = 4'hF;
    for (int k = 0; k < 3; k++) begin cycle(); exp_v = sb_q.pop_front(); end
    sync_in = 4'hB;
    cycle();
    exp_v = sb_q.pop_front();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    exp_v = sb_q.pop_front(); checks++;
    if (act_vec() !== exp_v || flt_lvl !== 4'hF || status !== 4'h0) begin
      failures++; $display("[TB] FAIL mid_rst flt=%h status=%h got=%h want=%h", flt_lvl, status, act_vec(), exp_v);
    end
    cycle();
    exp_v = sb_q.pop_front(); checks++;
    if (act_vec() !== exp_v || flt_lvl[2] !== 1'b1 || evt_pulse !== 4'h0) begin
      failures++; $display("[TB] FAIL mid_rst_e0 flt=%h pulse=%h got=%h want=%h", flt_lvl, evt_pulse, act_vec(), exp_v);
    end
    cycle();
    exp_v = sb_q.pop_front(); checks++;
    if (act_vec() !== exp_v || flt_lvl !== 4'hB || evt_pulse !== 4'h4) begin
      failures++; $display("[TB] FAIL mid_rst_e1 flt=%h pulse=%h got=%h want=%h", flt_lvl, evt_pulse, act_vec(), exp_v);
    end
  endtask

  initial begin
    for (int i = 0; i < WIDTH; i++) m_stab[i] = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_fall_event();
    test_glitch();
    test_status_clr();
    test_multi_bit();
    test_counter_sat();
    test_reset_mid_filter();
    checks++;
    if (sb_q.size() != 0) begin failures++; $display("[TB] FAIL sb_drain left=%0d want=0", sb_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
